// File: rtl/twiddle_seq_gen_if.sv
// Stream and control bundle between the twiddle sequencer and the FFT butterfly unit.
// master = sequencer side, slave = consumer side.
interface twiddle_seq_gen_if #(
  parameter int N = 16,
  parameter int K = 9
);
  localparam int LOG_N = $clog2(N);
  localparam int MW    = $clog2(LOG_N + 1);

  logic                    start;
  logic [MW-1:0]           cfg_log_m;
  logic [LOG_N-1:0]        cfg_stage;
  logic                    cfg_inv;
  logic                    busy;
  logic                    cfg_err;
  logic                    tw_valid;
  logic                    tw_ready;
  logic signed [K-1:0]     tw_re;
  logic signed [K-1:0]     tw_im;
  logic [LOG_N-2:0]        tw_idx;
  logic                    tw_last;

  modport master (
    input  start, cfg_log_m, cfg_stage, cfg_inv, tw_ready,
    output busy, cfg_err, tw_valid, tw_re, tw_im, tw_idx, tw_last
  );

  modport slave (
    output start, cfg_log_m, cfg_stage, cfg_inv, tw_ready,
    input  busy, cfg_err, tw_valid, tw_re, tw_im, tw_idx, tw_last
  );
endinterface

// File: rtl/twiddle_seq_gen.sv
// Radix-2 DIF twiddle sequencer: quarter-wave cosine ROM, symmetry rebuild, 2-stage valid/ready pipe.
// Optional macro TWIDDLE_INVERSE_EN enables conjugate (IFFT) output via cfg_inv.
module twiddle_seq_gen #(
  parameter int N = 16,
  parameter int K = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  twiddle_seq_gen_if.master tw_if
);
  localparam int LOG_N = $clog2(N);
  localparam int MW    = $clog2(LOG_N + 1);
  localparam int IW    = LOG_N - 1;
  localparam int EW    = LOG_N + 1;
  localparam int Q     = N / 4;

  localparam logic [EW-1:0] ONE_E = EW'(1);
  localparam logic [IW-1:0] QW    = IW'(Q);

  typedef logic [K-1:0]        mag_t;
  typedef logic [Q:0][K-1:0]   rom_t;

  function automatic rom_t build_rom();
    rom_t t;
    real  x;
    int   v;
    t = '0;
    for (int unsigned j = 0; j <= Q; j++) begin
      x = (2.0 ** (K - 1)) * $cos(2.0 * 3.14159265358979323846 * j / N);
      v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
      if (v > 2 ** (K - 1) - 1) v = 2 ** (K - 1) - 1;
      t[IW'(j)] = mag_t'(v);
    end
    return t;
  endfunction

  localparam rom_t COS_ROM = build_rom();

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [MW-1:0]    m_q;
  logic [LOG_N-1:0] s_q;
  logic [IW-1:0]    b_q;

  logic             cfg_ok, accept, err_set, issue, adv;
  logic [EW-1:0]    span;
  logic [IW-1:0]    bmask, lastb, k_issue, a_re, a_im;
  logic [EW-1:0]    shk;
  logic             quad;

  logic             p1_valid, p1_last, p1_quad;
  logic [IW-1:0]    p1_k;
  mag_t             p1_mre, p1_mim;

  logic             tw_valid_q, tw_last_q, cfg_err_q;
  logic [K-1:0]     tw_re_q, tw_im_q;
  logic [IW-1:0]    tw_idx_q;
  logic [K:0]       re_ext, im_ext, re_s, im_s;
  logic             conj;

`ifdef TWIDDLE_INVERSE_EN
  logic inv_q;
  assign conj = inv_q;
`else
  logic unused_inv;
  assign unused_inv = tw_if.cfg_inv;
  assign conj = 1'b0;
`endif

  assign cfg_ok = (tw_if.cfg_log_m != '0)
               && (EW'(tw_if.cfg_log_m) <= EW'(LOG_N))
               && (EW'(tw_if.cfg_stage) < EW'(tw_if.cfg_log_m));
  assign adv = !tw_valid_q || tw_if.tw_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tw_if.start && cfg_ok) state_nx = RUN;
      RUN:     if (adv && b_q == lastb) state_nx = DRAIN;
      DRAIN:   if (tw_valid_q && tw_if.tw_ready && tw_last_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept  = 1'b0;
    err_set = 1'b0;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        accept  = tw_if.start && cfg_ok;
        err_set = tw_if.start && !cfg_ok;
      end
      RUN:     issue = adv;
      default: ;
    endcase
  end

  // k = ((b mod (M >> (s+1))) << s) << (LOG_N - m); masks are powers of two
  always_comb begin
    span    = EW'(m_q) - EW'(s_q) - ONE_E;
    bmask   = IW'((ONE_E << span) - ONE_E);
    lastb   = IW'((ONE_E << (EW'(m_q) - ONE_E)) - ONE_E);
    shk     = EW'(LOG_N) - EW'(m_q);
    k_issue = ((b_q & bmask) << s_q) << shk;
    quad    = k_issue[IW-1];
    a_re    = quad ? QW - IW'(k_issue[IW-2:0]) : k_issue;
    a_im    = quad ? IW'(k_issue[IW-2:0])      : QW - k_issue;
  end

  always_comb begin
    re_ext = {1'b0, p1_mre};
    im_ext = {1'b0, p1_mim};
    re_s   = p1_quad ? -re_ext : re_ext;
    im_s   = conj ? im_ext : -im_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      s_q        <= '0;
      b_q        <= '0;
      cfg_err_q  <= 1'b0;
      p1_valid   <= 1'b0;
      p1_last    <= 1'b0;
      p1_quad    <= 1'b0;
      p1_k       <= '0;
      p1_mre     <= '0;
      p1_mim     <= '0;
      tw_valid_q <= 1'b0;
      tw_last_q  <= 1'b0;
      tw_re_q    <= '0;
      tw_im_q    <= '0;
      tw_idx_q   <= '0;
`ifdef TWIDDLE_INVERSE_EN
      inv_q      <= 1'b0;
`endif
    end else begin
      cfg_err_q <= err_set;
      if (accept) begin
        m_q <= tw_if.cfg_log_m;
        s_q <= tw_if.cfg_stage;
        b_q <= '0;
`ifdef TWIDDLE_INVERSE_EN
        inv_q <= tw_if.cfg_inv;
`endif
      end else if (issue) begin
        b_q <= b_q + IW'(1);
      end
      // Both stages move together so a stall freezes the whole pipe
      if (adv) begin
        p1_valid <= issue;
        if (issue) begin
          p1_k    <= k_issue;
          p1_last <= (b_q == lastb);
          p1_quad <= quad;
          p1_mre  <= COS_ROM[a_re];
          p1_mim  <= COS_ROM[a_im];
        end
        tw_valid_q <= p1_valid;
        tw_last_q  <= p1_valid && p1_last;
        tw_idx_q   <= p1_k;
        tw_re_q    <= re_s[K-1:0];
        tw_im_q    <= im_s[K-1:0];
      end
    end
  end

  assign tw_if.busy     = (state != IDLE);
  assign tw_if.cfg_err  = cfg_err_q;
  assign tw_if.tw_valid = tw_valid_q;
  assign tw_if.tw_last  = tw_last_q;
  assign tw_if.tw_idx   = tw_idx_q;
  assign tw_if.tw_re    = tw_re_q;
  assign tw_if.tw_im    = tw_im_q;
endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Directed bench for twiddle_seq_gen (N=16, K=9): vector table plus hand sequences for
// reset abort, random backpressure, config rejection and the conjugate option.
module tb_twiddle_seq_gen;
  localparam int N = 16;
  localparam int K = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twiddle_seq_gen_if #(.N(N), .K(K)) bus ();
  twiddle_seq_gen #(.N(N), .K(K)) dut (.clk(clk), .rst_n(rst_n), .tw_if(bus));

  typedef struct {
    int m; int s; int k; int re; int im; int last; int first;
  } vec_t;
  vec_t tbl[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int m, input int s, input int inv);
    bus.start     = 1'b1;
    bus.cfg_log_m = 3'(m);
    bus.cfg_stage = 4'(s);
    bus.cfg_inv   = inv[0];
    tick();
    bus.start     = 1'b0;
  endtask

  function automatic void add(input int m, input int s, input int b, input int k,
                              input int re, input int im, input int last);
    vec_t v;
    v.m = m; v.s = s; v.k = k; v.re = re; v.im = im; v.last = last; v.first = (b == 0);
    tbl.push_back(v);
  endfunction

  int lat, cyc, got, pend, rdy;
  int h_re, h_im, h_idx;
  int t2_re[8] = '{255, 237, 181, 98, 0, -98, -181, -237};
  int t2_im[8] = '{0, -98, -181, -237, -255, -237, -181, -98};

  initial begin
    bus.start = 1'b0; bus.cfg_log_m = '0; bus.cfg_stage = '0; bus.cfg_inv = 1'b0;
    bus.tw_ready = 1'b1;

    // T2: m=4, s=0 full sweep (rows 0..7 reused by the backpressure test)
    for (int b = 0; b < 8; b++) add(4, 0, b, b, t2_re[b], t2_im[b], b == 7);
    // T3: s=2 alternates k=0/4; s=3 holds k=0
    for (int b = 0; b < 8; b++)
      if (b % 2 == 0) add(4, 2, b, 0, 255, 0, b == 7);
      else            add(4, 2, b, 4, 0, -255, b == 7);
    for (int b = 0; b < 8; b++) add(4, 3, b, 0, 255, 0, b == 7);
    // T4: small sizes
    add(2, 0, 0, 0, 255, 0, 0);
    add(2, 0, 1, 4, 0, -255, 1);
    add(1, 0, 0, 0, 255, 0, 1);

    // Reset state
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.tw_valid, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk("rst_re", int'(bus.tw_re), 0);
    chk("rst_last", bus.tw_last, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: reset mid-run
    do_start(4, 0, 0);
    tick(); tick(); tick();
    chk("t1_valid_before", bus.tw_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("t1_async_valid", bus.tw_valid, 0);
    chk("t1_async_busy", bus.busy, 0);
    tick();
    chk("t1_valid", bus.tw_valid, 0);
    chk("t1_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven runs with tw_ready held high
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].first) begin
        do_start(tbl[i].m, tbl[i].s, 0);
        chk("busy_on_start", bus.busy, 1);
        lat = 0;
        while (!bus.tw_valid && lat < 20) begin tick(); lat++; end
        chk("first_latency", lat, 2);
      end else begin
        tick();
        chk("beat_valid", bus.tw_valid, 1);
      end
      chk("tw_idx", bus.tw_idx, tbl[i].k);
      chk("tw_re", int'(bus.tw_re), tbl[i].re);
      chk("tw_im", int'(bus.tw_im), tbl[i].im);
      chk("tw_last", bus.tw_last, tbl[i].last);
      if (tbl[i].last) begin
        tick();
        chk("busy_after_last", bus.busy, 0);
        chk("valid_after_last", bus.tw_valid, 0);
      end
    end

    // T5: random backpressure, plus a start pulse while busy
    bus.tw_ready = 1'b0;
    do_start(4, 0, 0);
    got = 0; cyc = 0; pend = 0; rdy = 0;
    while (got < 8 && cyc < 200) begin
      tick(); cyc++;
      if (pend != 0) begin
        chk("stall_valid", bus.tw_valid, 1);
        chk("stall_re", int'(bus.tw_re), h_re);
        chk("stall_im", int'(bus.tw_im), h_im);
        chk("stall_idx", bus.tw_idx, h_idx);
      end
      if (cyc == 4) begin
        bus.start = 1'b1; bus.cfg_log_m = 3'd5; bus.cfg_stage = '0;
      end
      if (cyc == 5) begin
        bus.start = 1'b0;
        chk("busy_start_no_err", bus.cfg_err, 0);
      end
      rdy = int'($urandom_range(0, 1));
      bus.tw_ready = rdy[0];
      if (bus.tw_valid) begin
        if (rdy != 0) begin
          chk("bp_idx", bus.tw_idx, tbl[got].k);
          chk("bp_re", int'(bus.tw_re), tbl[got].re);
          chk("bp_im", int'(bus.tw_im), tbl[got].im);
          chk("bp_last", bus.tw_last, tbl[got].last);
          got++;
          pend = 0;
        end else begin
          pend = 1;
          h_re = int'(bus.tw_re); h_im = int'(bus.tw_im); h_idx = int'(bus.tw_idx);
        end
      end else begin
        pend = 0;
      end
    end
    bus.start = 1'b0;
    chk("bp_beats", got, 8);
    tick();
    chk("bp_busy_end", bus.busy, 0);
    chk("bp_valid_end", bus.tw_valid, 0);
    bus.tw_ready = 1'b1;

    // T6: invalid configurations
    do_start(5, 0, 0);
    chk("err_m5", bus.cfg_err, 1);
    chk("err_m5_busy", bus.busy, 0);
    tick();
    chk("err_m5_pulse", bus.cfg_err, 0);
    chk("err_m5_valid", bus.tw_valid, 0);
    do_start(2, 2, 0);
    chk("err_s2", bus.cfg_err, 1);
    chk("err_s2_busy", bus.busy, 0);
    tick();
    chk("err_s2_pulse", bus.cfg_err, 0);
    do_start(0, 0, 0);
    chk("err_m0", bus.cfg_err, 1);
    tick();

    // Conjugate request: honoured only with the inverse option
    do_start(4, 0, 1);
    lat = 0;
    while (!bus.tw_valid && lat < 20) begin tick(); lat++; end
    chk("inv_latency", lat, 2);
    tick();
    tick();
    chk("inv_b2_idx", bus.tw_idx, 2);
    chk("inv_b2_re", int'(bus.tw_re), 181);
`ifdef TWIDDLE_INVERSE_EN
    chk("inv_b2_im", int'(bus.tw_im), 181);
`else
    chk("inv_b2_im", int'(bus.tw_im), -181);
`endif
    cyc = 0;
    while (bus.busy && cyc < 20) begin tick(); cyc++; end
    chk("inv_done", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
